// File: rtl/mdc_cfg_pkg.sv
// Shared definitions for the configurator: state codes, reserved ID and
// packed parameter-table field extraction.
package mdc_cfg_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_APPLY  = 2'd2;
  localparam logic [1:0] S_SETTLE = 2'd3;

  localparam int CFG_ID_NONE = 0;

  // Widest packed table / field the extraction helper handles.
  localparam int TBL_MAX = 1024;
  localparam int FLD_MAX = 64;

  function automatic logic [FLD_MAX-1:0] tbl_field(input logic [TBL_MAX-1:0] tbl,
                                                   input int k, input int w);
    logic [FLD_MAX-1:0] mask;
    mask = (FLD_MAX'(1) << w) - FLD_MAX'(1);
    return FLD_MAX'(tbl >> (k * w)) & mask;
  endfunction

endpackage

// File: rtl/cfg_lookup.sv
// CAM-style lookup of a configuration ID in a packed table; the lowest
// matching entry wins and the reserved ID never matches.
module cfg_lookup
  import mdc_cfg_pkg::*;
#(
  parameter int ID_W  = 8,
  parameter int SEL_W = 14,
  parameter int N_CFG = 2,
  parameter logic [N_CFG*ID_W-1:0]  CFG_IDS = {8'd2, 8'd1},
  parameter logic [N_CFG*SEL_W-1:0] CFG_SEL = {14'h3FFF, 14'h0000},
  localparam int IDX_W = (N_CFG > 1) ? $clog2(N_CFG) : 1
) (
  input  logic [ID_W-1:0]  id_in,
  output logic             hit,
  output logic [IDX_W-1:0] idx,
  output logic [SEL_W-1:0] sel_pat
);

  // Descending scan so the lowest matching index is the last assignment.
  always_comb begin
    hit     = 1'b0;
    idx     = '0;
    sel_pat = '0;
    for (int k = N_CFG - 1; k >= 0; k--) begin
      if (id_in != ID_W'(CFG_ID_NONE) &&
          tbl_field(TBL_MAX'(CFG_IDS), k, ID_W) == FLD_MAX'(id_in)) begin
        hit     = 1'b1;
        idx     = IDX_W'(k);
        sel_pat = SEL_W'(tbl_field(TBL_MAX'(CFG_SEL), k, SEL_W));
      end
    end
  end

endmodule

// File: rtl/configurator_seq.sv
// Sequential configurator: accepts an ID, stalls and drains the datapath,
// switches the select bus, waits a settle window, then reports done/err.
module configurator_seq
  import mdc_cfg_pkg::*;
#(
  parameter int ID_W  = 8,
  parameter int SEL_W = 14,
  parameter int N_CFG = 2,
  parameter logic [N_CFG*ID_W-1:0]  CFG_IDS = {8'd2, 8'd1},
  parameter logic [N_CFG*SEL_W-1:0] CFG_SEL = {14'h3FFF, 14'h0000},
  parameter logic [SEL_W-1:0]       RESET_SEL = 14'h0000,
  parameter int DRAIN_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [ID_W-1:0]  id_in,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic             dp_idle,
  output logic             dp_hold,
  output logic [SEL_W-1:0] sel,
  output logic [ID_W-1:0]  cur_id,
  output logic             cfg_done,
  output logic             cfg_err
);

  localparam int IDX_W   = (N_CFG > 1) ? $clog2(N_CFG) : 1;
  localparam int CNT_MAX = (DRAIN_CYCLES > SETTLE_CYCLES) ? DRAIN_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  logic [1:0]       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [ID_W-1:0]  req_id, req_id_nx, cur_id_nx;
  logic [SEL_W-1:0] req_sel, req_sel_nx, sel_nx;
  logic             dp_hold_nx, cfg_done_nx, cfg_err_nx;

  logic             lk_hit;
  logic [IDX_W-1:0] lk_idx;
  logic [SEL_W-1:0] lk_sel;

  cfg_lookup #(
    .ID_W(ID_W), .SEL_W(SEL_W), .N_CFG(N_CFG), .CFG_IDS(CFG_IDS), .CFG_SEL(CFG_SEL)
  ) u_lookup (
    .id_in(id_in), .hit(lk_hit), .idx(lk_idx), .sel_pat(lk_sel)
  );

  assign id_ready = (state == S_IDLE);

  logic accept, same_id, drain_last, settle_last;
  assign accept      = id_valid & id_ready;
  assign same_id     = (id_in == cur_id);
  // Terminal counts look one increment ahead so each phase lasts exactly N cycles.
  assign drain_last  = (32'(cnt) + 32'd1) >= DRAIN_CYCLES;
  assign settle_last = (32'(cnt) + 32'd1) >= SETTLE_CYCLES;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      req_id   <= '0;
      req_sel  <= '0;
      sel      <= RESET_SEL;
      cur_id   <= '0;
      dp_hold  <= 1'b0;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      req_id   <= req_id_nx;
      req_sel  <= req_sel_nx;
      sel      <= sel_nx;
      cur_id   <= cur_id_nx;
      dp_hold  <= dp_hold_nx;
      cfg_done <= cfg_done_nx;
      cfg_err  <= cfg_err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (accept && lk_hit && !same_id) state_nx = S_DRAIN;
      S_DRAIN:  if (dp_idle && drain_last) state_nx = S_APPLY;
      S_APPLY:  state_nx = (SETTLE_CYCLES == 0) ? S_IDLE : S_SETTLE;
      S_SETTLE: if (settle_last) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_nx      = '0;
    req_id_nx   = req_id;
    req_sel_nx  = req_sel;
    sel_nx      = sel;
    cur_id_nx   = cur_id;
    dp_hold_nx  = dp_hold;
    cfg_done_nx = 1'b0;
    cfg_err_nx  = 1'b0;
    case (state)
      S_IDLE: if (accept) begin
        req_id_nx  = id_in;
        req_sel_nx = lk_sel;
        if (!lk_hit)      cfg_err_nx  = 1'b1;
        else if (same_id) cfg_done_nx = 1'b1;
        else              dp_hold_nx  = 1'b1;
      end
      S_DRAIN: if (dp_idle && !drain_last) cnt_nx = cnt + CNT_W'(1);
      S_APPLY: begin
        sel_nx    = req_sel;
        cur_id_nx = req_id;
        if (SETTLE_CYCLES == 0) begin
          dp_hold_nx  = 1'b0;
          cfg_done_nx = 1'b1;
        end
      end
      S_SETTLE: begin
        if (settle_last) begin
          dp_hold_nx  = 1'b0;
          cfg_done_nx = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Index must always land inside the table when the lookup hits.
  a_idx_range: assert property (@(posedge clock) disable iff (!reset)
    (id_valid && lk_hit) |-> (32'(lk_idx) < N_CFG));

endmodule
